// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port for (a - b) mod 2^WIDTH.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sub_r;

  logic b_bit;
  logic s0;
  logic c0;
  logic s1;
  logic c1;

`ifndef SERIAL_ADDER_SUB_EN
  assign sub_r = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert B on entry, carry seeded with 1 at accept.
  assign b_bit = b_sr[0] ^ sub_r;

  half_adder u_ha0 (.x(a_sr[0]), .y(b_bit), .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0),      .y(carry), .s(s1), .c(c1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r <= sub;
            carry <= sub;
`else
            carry <= 1'b0;
`endif
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r <= {s1, sum_r[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= c0 | c1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode registered state only; no input-to-output path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry;

endmodule

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
// Honors SERIAL_ADDER_SUB_EN the same way as the design.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-precision result.
  task automatic ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tsub,
                           output logic [W-1:0] es, output logic ec);
    int unsigned full;
    if (tsub) begin
      es = W'((int'(ta) - int'(tb_in)) & ((1 << W) - 1));
      ec = (ta >= tb_in);
    end else begin
      full = int'(ta) + int'(tb_in);
      es = W'(full);
      ec = full[W];
    end
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tsub,
                         input int hold);
    logic [W-1:0] es;
    logic         ec;
    int           lat;
    ref_model(ta, tb_in, tsub, es, ec);
    check("pre_in_ready", in_ready, 1);
    a = ta; b = tb_in; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("in_ready_fall", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    check("sum", sum, es);
    check("cout", cout, ec);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, es);
      check("hold_cout", cout, ec);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    logic tsub;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    run_txn(8'h3C, 8'h05, 1'b0, 0);
    run_txn(8'hFF, 8'h01, 1'b0, 0);
    run_txn(8'hFF, 8'hFF, 1'b0, 0);
    run_txn(8'h10, 8'h20, 1'b0, 5);

    // Abort mid-run: nothing from the aborted pair may surface.
    a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", out_valid, 0);
    end
    run_txn(8'h01, 8'h01, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_txn(8'h05, 8'h07, 1'b1, 0);
    run_txn(8'h07, 8'h05, 1'b1, 0);
`endif

    for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      tsub = 1'($urandom);
`else
      tsub = 1'b0;
`endif
      run_txn(W'($urandom), W'($urandom), tsub, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that consumes one operand pair per transaction and processes it LSB-first, one bit per clock. The datapath is a single full adder built from two `half_adder` instances plus an OR gate, with a carry flip-flop and shift registers around it. It sits directly downstream of operand sources with a valid/ready handshake and trades throughput for a one-bit datapath.

## Interface
- `WIDTH`, 8: operand and sum width in bits; legal range 2 to 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair on `a` and `b` is valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  WIDTH  operand A, unsigned.
- `b`  in  WIDTH  operand B, unsigned.
- `sub`  in  1  subtract select; present only when `SERIAL_ADDER_SUB_EN` is defined.
- `out_valid`  out  1  `sum` and `cout` hold a finished result.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result modulo 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `a` and `b` (and `sub`) into shift registers, clear the carry flip-flop (set it to 1 when subtracting), clear the bit counter, and go to RUN.
- RUN:
  - `in_ready`=0.
  - Each cycle, add the LSBs of the A and B shift registers and the carry flip-flop.
  - Shift the sum bit into the MSB of `sum` and shift both operand registers right.
  - Update the carry flip-flop and increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - `out_valid`=1; `sum` and `cout` are stable.
  - On `out_valid`&`out_ready`, go to IDLE.
  - While `out_ready`=0, hold all outputs indefinitely.
- Arithmetic:
  - `sum` = (a + b) mod 2^WIDTH.
  - `cout` = bit WIDTH of the full-precision sum.
- Inputs `a`, `b` and `sub` are sampled only on the accept edge. Changes during RUN or DONE are ignored.
- `in_valid` while not in IDLE: no effect. The upstream must hold its data until it sees `in_ready`.
- Bit counter: width $clog2(WIDTH)+1 bits. It never wraps during a transaction.
- Reset:
  - `rst`=1 in any state, including mid-RUN, aborts the transaction at the next edge.
  - After reset: state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, carry flip-flop=0, counter=0.
  - A partially computed result is discarded and is never presented.
- `sum` reads as partial or shifting data during RUN. Consumers use it only when `out_valid`=1.

## Timing
- Accept edge = E0. RUN covers edges E1..EWIDTH. `out_valid` rises after edge EWIDTH, i.e. WIDTH cycles after E0.
- `in_ready` falls the cycle after E0. It rises the cycle after the output handshake edge.
- No overlap between transactions. The minimum period between accepts is WIDTH+2 cycles, with `out_ready` tied high.
- No combinational path from any input to any output. `in_ready` and `out_valid` are decoded from registered state only.

## Configuration
- Macro: `SERIAL_ADDER_SUB_EN`.
- Defined:
  - The `sub` port exists.
  - With `sub`=1, B is bit-inverted as it enters the adder and the carry flip-flop initialises to 1, so `sum` = (a − b) mod 2^WIDTH.
  - In that case `cout`=1 means no borrow (a ≥ b).
  - With `sub`=0, behaviour is identical to the undefined case.
- Undefined:
  - No `sub` port.
  - Addition only; carry initialises to 0.

## Test plan
- Reset with WIDTH=8: hold `rst` 2 cycles -> `in_ready`=1, `out_valid`=0, `sum`=0x00, `cout`=0.
- Basic add: a=0x3C, b=0x05 accepted at E0, `out_ready`=1 -> `out_valid` high exactly 8 cycles later with `sum`=0x41, `cout`=0; `in_ready` high the following cycle.
- Carry and wrap: a=0xFF, b=0x01 -> `sum`=0x00, `cout`=1. Then a=0xFF, b=0xFF -> `sum`=0xFE, `cout`=1.
- Backpressure: a=0x10, b=0x20 with `out_ready` low for 5 cycles after `out_valid` -> `sum`=0x30 stable throughout. `in_ready`=0 and a second `in_valid` pulse is ignored. The handshake on cycle 6 returns the FSM to IDLE.
- Reset mid-run: accept a=0xAA, b=0x55 and assert `rst` at bit 3 -> next cycle IDLE, `out_valid`=0, `sum`=0. A following 0x01+0x01 yields 0x02.
- With `SERIAL_ADDER_SUB_EN` defined: a=0x05, b=0x07, `sub`=1 -> `sum`=0xFE, `cout`=0. Then a=0x07, b=0x05 -> `sum`=0x02, `cout`=1. Also run 1000 random add/sub pairs checked against a reference model.
